// File: rtl/ccm_buf_ctrl.sv
// rtl/ccm_buf_ctrl.sv - streaming FIFO controller over the CCM 257x8 register array
// Slot CAP is the park slot that absorbs the array's unconditional write when no word is accepted.
module ccm_buf_ctrl #(
  parameter int DW    = 8,
  parameter int PTR_W = 9,
  parameter int CAP   = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic [PTR_W-1:0] arr_wr_ptr,
  output logic [DW-1:0]    arr_data_in,
  output logic [PTR_W-1:0] arr_rd_ptr,
  input  logic [DW-1:0]    arr_data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [8:0]       occupancy,
  output logic             full,
  output logic             empty
);

  localparam int HW = PTR_W - 1;

  logic [HW-1:0]    r_wr_head;
  logic [HW-1:0]    r_rd_head;
  logic [PTR_W-1:0] r_mem_cnt;
  logic             r_inflight;
  logic [DW-1:0]    r_skid0;
  logic [DW-1:0]    r_skid1;
  logic [1:0]       r_skid_cnt;

  logic       w_wr_fire;
  logic       w_pop;
  logic       w_rd_fire;
  logic [2:0] w_credit_used;
  logic [2:0] w_credit_lim;

  assign in_ready   = !rst_n && (r_mem_cnt != PTR_W'(CAP));
  assign w_wr_fire  = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;

  // A read may issue only if its result will find room in the skid buffer after this cycle's pop.
  assign w_credit_used = 3'(r_inflight) + 3'(r_skid_cnt);
  assign w_credit_lim  = 3'd2 + 3'(w_pop);
  assign w_rd_fire     = (r_mem_cnt != '0) && (w_credit_used < w_credit_lim);

  assign arr_wr_ptr  = w_wr_fire ? {1'b0, r_wr_head} : PTR_W'(CAP);
  assign arr_data_in = in_data;
  assign arr_rd_ptr  = {1'b0, r_rd_head};

  assign out_valid = (r_skid_cnt != 2'd0);
  assign out_data  = r_skid0;
  assign occupancy = 9'(r_mem_cnt) + 9'(r_inflight) + 9'(r_skid_cnt);
  assign full      = (r_mem_cnt == PTR_W'(CAP));
  assign empty     = (occupancy == 9'd0);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_head  <= '0;
      r_rd_head  <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_skid0    <= '0;
      r_skid1    <= '0;
      r_skid_cnt <= 2'd0;
    end else begin
      if (w_wr_fire) r_wr_head <= r_wr_head + 1'b1;
      if (w_rd_fire) r_rd_head <= r_rd_head + 1'b1;
      r_mem_cnt  <= r_mem_cnt + PTR_W'(w_wr_fire) - PTR_W'(w_rd_fire);
      r_inflight <= w_rd_fire;
      r_skid_cnt <= r_skid_cnt + 2'(r_inflight) - 2'(w_pop);
      // The captured word lands at position skid_cnt - pop.
      case ({r_inflight, w_pop})
        2'b01: r_skid0 <= r_skid1;
        2'b10: begin
          if (r_skid_cnt == 2'd0) r_skid0 <= arr_data_out;
          else                    r_skid1 <= arr_data_out;
        end
        2'b11: begin
          if (r_skid_cnt == 2'd1) begin
            r_skid0 <= arr_data_out;
          end else begin
            r_skid0 <= r_skid1;
            r_skid1 <= arr_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccm_buf_ctrl.sv
// tb/tb_ccm_buf_ctrl.sv - self-checking bench for ccm_buf_ctrl with an array model and queue scoreboard
module tb_ccm_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [8:0] arr_wr_ptr;
  logic [7:0] arr_data_in;
  logic [8:0] arr_rd_ptr;
  logic [7:0] arr_data_out = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [8:0] occupancy;
  logic       full;
  logic       empty;

  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  logic [7:0] words[1000];
  logic [7:0] mem[0:256];

  always #5 clk = ~clk;

  ccm_buf_ctrl #(.DW(8), .PTR_W(9), .CAP(256)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .arr_wr_ptr(arr_wr_ptr), .arr_data_in(arr_data_in), .arr_rd_ptr(arr_rd_ptr),
    .arr_data_out(arr_data_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy), .full(full), .empty(empty)
  );

  // 257x8 array: unconditional write, registered read returning the pre-write value.
  initial for (int i = 0; i < 257; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    mem[arr_wr_ptr] <= arr_data_in;
    arr_data_out    <= mem[arr_rd_ptr];
  end

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_during: got %b want 0", in_ready); end
    total++; if (arr_wr_ptr !== 9'd256) begin bad++; $display("FAIL reset_wr_park: got %0d want 256", arr_wr_ptr); end
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    total++; if (occupancy !== 9'd0) begin bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    q.delete();
  endtask

  task automatic test_single;
    do_reset();
    drive(1'b1, 8'hA5, 1'b1);
    total++; if (arr_wr_ptr !== 9'd0) begin bad++; $display("FAIL single_wr_ptr: got %0d want 0", arr_wr_ptr); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    for (int c = 1; c <= 6; c++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (c == 1) begin
        total++; if (arr_rd_ptr !== 9'd0) begin bad++; $display("FAIL single_rd_ptr_c1: got %0d want 0", arr_rd_ptr); end
      end
      if (c == 2) begin
        total++; if (arr_rd_ptr !== 9'd1) begin bad++; $display("FAIL single_rd_ptr_c2: got %0d want 1", arr_rd_ptr); end
      end
      total++; if (out_valid !== (c == 3)) begin bad++; $display("FAIL single_out_valid_c%0d: got %b want %b", c, out_valid, (c == 3)); end
      if (c == 3) begin
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_out_data: got %0h want a5", out_data); end
      end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty: got %b want 1", empty); end
  endtask

  task automatic test_park;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 8'($urandom), 1'($urandom));
      total++; if (arr_wr_ptr !== 9'd256) begin bad++; $display("FAIL park_wr_ptr_c%0d: got %0d want 256", c, arr_wr_ptr); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL park_out_valid_c%0d: got %b want 0", c, out_valid); end
      total++; if (occupancy !== 9'd0) begin bad++; $display("FAIL park_occupancy_c%0d: got %0d want 0", c, occupancy); end
    end
  endtask

  task automatic test_fill;
    int nxt;
    do_reset();
    nxt = 0;
    for (int c = 0; c < 300; c++) begin
      drive(1'b1, 8'(nxt), 1'b0);
      if (out_valid === 1'b1) begin
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL fill_hold_c%0d: got %0h want 0", c, out_data); end
      end
      if (in_valid && in_ready) begin q.push_back(8'(nxt)); nxt++; end
    end
    drive(1'b0, 8'h00, 1'b0);
    total++; if (nxt !== 258) begin bad++; $display("FAIL fill_accepted: got %0d want 258", nxt); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", full); end
    total++; if (occupancy !== 9'd258) begin bad++; $display("FAIL fill_occupancy: got %0d want 258", occupancy); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fill_out_valid: got %b want 1", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL fill_out_data: got %0h want 0", out_data); end
  endtask

  task automatic test_drain;
    logic [7:0] exp;
    for (int c = 0; c < 258; c++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (c == 0) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL drain_in_ready_c0: got %b want 0", in_ready); end
      end
      if (c == 1) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_in_ready_c1: got %b want 1", in_ready); end
      end
      exp = (q.size() != 0) ? q.pop_front() : 8'h00;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_bubble_c%0d: got %b want 1", c, out_valid); end
      total++; if (out_data !== exp) begin bad++; $display("FAIL drain_data_c%0d: got %0h want %0h", c, out_data, exp); end
    end
    drive(1'b0, 8'h00, 1'b1);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_wrap;
    int nxt, popped, cyc;
    logic iv, ordy, acc, pp;
    logic [7:0] exp;
    do_reset();
    nxt = 0; popped = 0; cyc = 0;
    for (int i = 0; i < 1000; i++) words[i] = 8'($urandom);
    while (popped < 1000 && cyc < 20000) begin
      iv   = (nxt < 1000) && ($urandom_range(1, 0) == 1);
      ordy = ($urandom_range(1, 0) == 1);
      drive(iv, words[(nxt < 1000) ? nxt : 999], ordy);
      cyc++;
      acc = in_valid && in_ready;
      pp  = out_valid && out_ready;
      total++; if (occupancy !== 9'(q.size())) begin bad++; $display("FAIL wrap_occupancy_c%0d: got %0d want %0d", cyc, occupancy, q.size()); end
      total++; if (empty !== (q.size() == 0)) begin bad++; $display("FAIL wrap_empty_c%0d: got %b want %b", cyc, empty, (q.size() == 0)); end
      if (q.size() < 256) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL wrap_in_ready_c%0d: got %b want 1", cyc, in_ready); end
      end
      if (acc) begin
        total++; if (arr_wr_ptr !== 9'(nxt % 256)) begin bad++; $display("FAIL wrap_wr_ptr_c%0d: got %0d want %0d", cyc, arr_wr_ptr, nxt % 256); end
      end else begin
        total++; if (arr_wr_ptr !== 9'd256) begin bad++; $display("FAIL wrap_park_c%0d: got %0d want 256", cyc, arr_wr_ptr); end
      end
      if (pp) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL wrap_spurious_c%0d: got out_valid=1 want 0", cyc);
        end else begin
          exp = q.pop_front();
          if (out_data !== exp) begin bad++; $display("FAIL wrap_data_w%0d: got %0h want %0h", popped, out_data, exp); end
        end
        popped++;
      end
      if (acc) begin q.push_back(words[nxt]); nxt++; end
    end
    total++; if (popped != 1000) begin bad++; $display("FAIL wrap_timeout: got %0d popped want 1000", popped); end
  endtask

  task automatic test_reset_mid;
    int c;
    do_reset();
    for (int i = 0; i < 100; i++) drive(1'b1, 8'(i + 7), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    total++; if (occupancy !== 9'd100) begin bad++; $display("FAIL mid_pre_occupancy: got %0d want 100", occupancy); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete();
    total++; if (occupancy !== 9'd0) begin bad++; $display("FAIL mid_occupancy: got %0d want 0", occupancy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    total++; if (arr_wr_ptr !== 9'd256) begin bad++; $display("FAIL mid_wr_park: got %0d want 256", arr_wr_ptr); end
    drive(1'b1, 8'h3C, 1'b1);
    c = 0;
    do begin
      drive(1'b0, 8'h00, 1'b1);
      c++;
    end while (out_valid !== 1'b1 && c < 10);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_timeout: got out_valid=%b want 1", out_valid); end
    total++; if (out_data !== 8'h3C) begin bad++; $display("FAIL mid_first_word: got %0h want 3c", out_data); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_park();
    test_fill();
    test_drain();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccm_buf_ctrl.md
Name: ccm_buf_ctrl

Overview:
Pointer and flow-control controller that turns the CCM 257x8 register array into a streaming 256-deep FIFO with valid/ready handshakes on both sides.
- Write side: drives the array's wr_ptr and data_in.
- Read side: drives rd_ptr, absorbs the array's 1-cycle registered read, and presents data through a 2-entry output skid buffer.
- The array has no write enable, so slot 256 is a permanent scratch ("park") slot.

Parameters:
DW, 8, data width (matches array)
PTR_W, 9, array pointer width
CAP, 256, usable array entries (indices 0..CAP-1); park slot index = CAP

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock, reset synchronous and active-high (asserted = 1; port name kept per codebase naming)
in_valid  input  1  upstream data valid
in_ready  output  1  controller can accept in_data
in_data  input  DW  upstream data
arr_wr_ptr  output  PTR_W  to array wr_ptr
arr_data_in  output  DW  to array data_in
arr_rd_ptr  output  PTR_W  to array rd_ptr
arr_data_out  input  DW  from array data_out (registered, 1-cycle read latency)
out_valid  output  1  downstream data valid
out_ready  input  1  downstream accepts
out_data  output  DW  downstream data
occupancy  output  9  mem_cnt + inflight + skid_cnt (0..258)
full  output  1  mem_cnt == CAP
empty  output  1  occupancy == 0

Behaviour:
- State registers:
  - wr_head, rd_head: 8-bit index 0..255, wrapping 255 -> 0.
  - mem_cnt: 0..256.
  - inflight: 1 bit; read issued last cycle.
  - skid[0:1] with skid_cnt: 0..2.
- Reset (rst_n=1 at posedge):
  - All state cleared to 0.
  - Outputs while in reset or after it: in_ready=0 during the reset cycle and 1 after; out_valid=0, out_data=0, occupancy=0, full=0, empty=1.
  - Array contents are not cleared; stale data is never exposed because all counts are 0.
- Write:
  - in_ready = !rst_n && (mem_cnt != CAP); depends only on registered state.
  - wr_fire = in_valid && in_ready.
  - arr_wr_ptr = wr_fire ? {1'b0, wr_head} : CAP (park); arr_data_in = in_data, combinational.
  - On wr_fire, wr_head increments.
- Read issue:
  - pop = out_valid && out_ready.
  - rd_fire = (mem_cnt != 0) && (inflight + skid_cnt - pop < 2).
  - arr_rd_ptr = {1'b0, rd_head} at all times.
  - On rd_fire, rd_head increments and inflight <= 1; otherwise inflight <= 0.
- mem_cnt next = mem_cnt + wr_fire - rd_fire. A simultaneous write and read leaves it unchanged.
- Capture: when inflight=1, arr_data_out is pushed into the skid FIFO in that cycle.
- Skid FIFO:
  - FIFO order; out_data = skid[0]; out_valid = skid_cnt != 0.
  - Push and pop in the same cycle are allowed.
  - Credit rule guarantees no overflow.
- Hazards:
  - A read only targets slots whose write has already committed (mem_cnt is updated at the end of the write cycle).
  - A slot freed by rd_fire can be rewritten from the next cycle on; the array sampled the old value at the issue edge.
- Latency: a word accepted in cycle 0 (empty controller) gives rd_fire in cycle 1, capture in cycle 2, and out_valid=1 in cycle 3.
- Throughput: 1 word/cycle sustained with out_ready=1.
- Total capacity: 258 words (256 in array + 2 in skid).
- AXI-style stability: out_valid/out_data hold while out_ready=0. Upstream must hold in_data while in_valid && !in_ready.
- Reset mid-operation: all in-flight data is discarded. The next cycle matches post-reset state and arr_wr_ptr=CAP.

Test Plan:
- Single word: after reset, in_data=8'hA5 for one cycle with out_ready=1 -> arr_wr_ptr=0 that cycle, arr_rd_ptr=0 at cycle 1, out_valid=1 and out_data=8'hA5 at cycle 3 only, then empty=1.
- Park: in_valid=0 for 20 cycles -> arr_wr_ptr=256 every cycle; out_valid stays 0; occupancy=0.
- Fill: out_ready=0, continuous in_valid with values 0..299 -> exactly 258 accepted, in_ready=0 afterwards, full=1, occupancy=258, out_data=0 held stable.
- Drain after fill: out_ready=1 -> 258 words out in order 0..257, one per cycle with no bubble; in_ready re-asserts 1 cycle after the first read issue.
- Wrap and stream: 1000 words with random in_valid/out_ready (50%) -> output order exact, pointers wrap 255 -> 0, no word lost or duplicated; occupancy always equals accepted minus popped.
- Reset mid-stream: assert rst_n=1 with occupancy=100 -> next cycle occupancy=0, out_valid=0; then send 8'h3C -> it is the first word out.
